// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment loopback monitor: the active-low
// digit patterns (identical to the display driver's encoding) and the
// one-hot digit strobes, plus small helpers for the strobe.
package seg7_pkg;

    // Full 8-bit active-low patterns, decimal point (bit 0) off.
    localparam logic [7:0] ZERO  = 8'h03;
    localparam logic [7:0] ONE   = 8'h9F;
    localparam logic [7:0] TWO   = 8'h25;
    localparam logic [7:0] THREE = 8'h0D;
    localparam logic [7:0] FOUR  = 8'h99;
    localparam logic [7:0] FIVE  = 8'h49;
    localparam logic [7:0] SIX   = 8'h41;
    localparam logic [7:0] SEVEN = 8'h1F;
    localparam logic [7:0] EIGHT = 8'h01;
    localparam logic [7:0] NINE  = 8'h09;

    localparam logic [3:0] DIGIT_ONES      = 4'b0001;
    localparam logic [3:0] DIGIT_TENS      = 4'b0010;
    localparam logic [3:0] DIGIT_HUNDREDS  = 4'b0100;
    localparam logic [3:0] DIGIT_THOUSANDS = 4'b1000;

    // True when exactly one strobe line is active.
    function automatic logic is_onehot4(input logic [3:0] d);
        case (d)
            DIGIT_ONES, DIGIT_TENS, DIGIT_HUNDREDS, DIGIT_THOUSANDS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Nibble position of a one-hot strobe; meaningless for other values.
    function automatic logic [1:0] digit_index(input logic [3:0] d);
        case (d)
            DIGIT_TENS:      return 2'd1;
            DIGIT_HUNDREDS:  return 2'd2;
            DIGIT_THOUSANDS: return 2'd3;
            default:         return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the display driver's segment encoder: maps the
// seven segment lines back to a BCD nibble and flags unknown patterns.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_ok
);

    logic [7:0] w_full;

    // Rebuild the 8-bit form so the table compares against the shared constants.
    assign w_full = {i_pattern, 1'b1};

    // Table lookup; anything outside the ten digits is reported as not ok.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_nibble = 4'd0;
        o_ok     = 1'b1;
        case (w_full)
            ZERO:    o_nibble = 4'd0;
            ONE:     o_nibble = 4'd1;
            TWO:     o_nibble = 4'd2;
            THREE:   o_nibble = 4'd3;
            FOUR:    o_nibble = 4'd4;
            FIVE:    o_nibble = 4'd5;
            SIX:     o_nibble = 4'd6;
            SEVEN:   o_nibble = 4'd7;
            EIGHT:   o_nibble = 4'd8;
            NINE:    o_nibble = 4'd9;
            default: o_ok     = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Receive-side monitor for the multiplexed 4-digit seven-segment bus.
// Samples each settled digit strobe, decodes it back to BCD, assembles a
// 16-bit frame, and flags bad strobes, unknown patterns and a stalled scan.
// SETTLE_CYCLES must be at least 2 and below TIMEOUT_CYCLES.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic        clk_50MHz,
    input  logic        reset_button,
    input  logic [7:0]  seg,
    input  logic [3:0]  digit,
    output logic [15:0] bcd,
    output logic        valid,
    output logic        err_pattern,
    output logic        err_digit,
    output logic        stale
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES);
    localparam int STALL_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_FIRE = SETTLE_W'(SETTLE_CYCLES - 2);
    localparam logic [STALL_W-1:0]  STALL_LAST  = STALL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STALL_W-1:0]  STALL_FIRE  = STALL_W'(TIMEOUT_CYCLES - 2);

    logic [7:0]          r_seg, r_seg_prev;
    logic [3:0]          r_digit, r_digit_prev;
    logic [SETTLE_W-1:0] r_settle;
    logic [STALL_W-1:0]  r_stall;
    logic [3:0]          r_seen;
    logic [15:0]         r_shadow;
    logic [15:0]         r_bcd;
    logic                r_valid, r_err_pattern, r_err_digit, r_stale;

    logic       w_bus_changed, w_digit_changed;
    logic       w_sample, w_timeout;
    logic       w_digit_ok, w_pattern_ok, w_write;
    logic [1:0] w_idx;
    logic [3:0] w_nibble;
    logic       w_frame_done, w_stall_drop;
    logic [3:0] w_seen_upd;

    seg7_pattern_decode u_decode (
        .i_pattern (r_seg[7:1]),
        .o_nibble  (w_nibble),
        .o_ok      (w_pattern_ok)
    );

    assign w_bus_changed   = (r_seg != r_seg_prev) || (r_digit != r_digit_prev);
    assign w_digit_changed = (r_digit != r_digit_prev);
    // Fire on the transition into the saturated value, so once per dwell.
    assign w_sample        = !w_bus_changed && (r_settle == SETTLE_FIRE);
    assign w_timeout       = !w_digit_changed && (r_stall == STALL_FIRE);
    assign w_digit_ok      = is_onehot4(r_digit);
    assign w_idx           = digit_index(r_digit);
    assign w_write         = w_sample && w_digit_ok && w_pattern_ok;
    assign w_frame_done    = (r_seen == 4'b1111);
    // A one-hot strobe is already the seen mask for its digit.
    assign w_seen_upd      = (w_frame_done ? 4'b0000 : r_seen) | (w_write ? r_digit : 4'b0000);
    // A sample that fills the frame, or a frame being handed out, beats the stall.
    assign w_stall_drop    = w_timeout && !w_frame_done && (w_seen_upd != 4'b1111);

    // Register the pins once and keep the previous copy for change detection.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            r_seg        <= 8'h00;
            r_digit      <= 4'h0;
            r_seg_prev   <= 8'h00;
            r_digit_prev <= 4'h0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            r_seg        <= seg;
            r_digit      <= digit;
            r_seg_prev   <= r_seg;
            r_digit_prev <= r_digit;
        end
    end

    // Settle counter (any bus change) and stall counter (strobe change), both saturating.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            r_settle <= '0;
            r_stall  <= '0;
        end else begin
            if (w_bus_changed)
                r_settle <= '0;
            else if (r_settle != SETTLE_LAST)
                r_settle <= r_settle + 1'b1;

            if (w_digit_changed)
                r_stall <= '0;
            else if (r_stall != STALL_LAST)
                r_stall <= r_stall + 1'b1;
        end
    end

    // Shadow nibbles and the seen mask; the newest sample of a digit wins.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            r_seen   <= 4'b0000;
            r_shadow <= 16'h0000;
        end else begin
            if (w_write)
                r_shadow[{w_idx, 2'b00} +: 4] <= w_nibble;
            r_seen <= w_stall_drop ? 4'b0000 : w_seen_upd;
        end
    end

    // Frame hand-off, sticky error flags and the stall indicator.
    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            r_bcd         <= 16'h0000;
            r_valid       <= 1'b0;
            r_err_pattern <= 1'b0;
            r_err_digit   <= 1'b0;
            r_stale       <= 1'b0;
        end else begin
            r_valid <= w_frame_done;
            if (w_frame_done)
                r_bcd <= r_shadow;

            if (w_sample && !w_pattern_ok)
                r_err_pattern <= 1'b1;
            if (w_sample && !w_digit_ok)
                r_err_digit <= 1'b1;

            if (w_frame_done)
                r_stale <= 1'b0;
            else if (w_stall_drop)
                r_stale <= 1'b1;
        end
    end

    assign bcd         = r_bcd;
    assign valid       = r_valid;
    assign err_pattern = r_err_pattern;
    assign err_digit   = r_err_digit;
    assign stale       = r_stale;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: table-driven scans, hand-written corner cases and
// a randomized phase, all compared every cycle against a run-length model.
`timescale 1ns/1ps
module tb_seg7_capture;

    localparam int S     = 16;   // settle cycles (scaled down)
    localparam int T     = 300;  // stall timeout (scaled down)
    localparam int DWELL = 40;   // driver dwell per digit

    logic        clk_50MHz = 1'b0;
    logic        reset_button = 1'b0;
    logic [7:0]  seg = 8'h0D;
    logic [3:0]  digit = 4'b0001;
    logic [15:0] bcd;
    logic        valid, err_pattern, err_digit, stale;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid_dut = 0;

    seg7_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk_50MHz    (clk_50MHz),
        .reset_button (reset_button),
        .seg          (seg),
        .digit        (digit),
        .bcd          (bcd),
        .valid        (valid),
        .err_pattern  (err_pattern),
        .err_digit    (err_digit),
        .stale        (stale)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Digit value v is displayed by pattern ref_pat[v].
    logic [7:0] ref_pat [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    function automatic int decode_ref(input logic [7:0] s);
        for (int v = 0; v < 10; v++)
            if (ref_pat[v][7:1] == s[7:1]) return v;
        return -1;
    endfunction

    logic [15:0] m_bcd, m_shadow;
    logic        m_valid, m_ep, m_ed, m_stale;
    logic [3:0]  m_seen;
    logic [7:0]  m_prev_seg;
    logic [3:0]  m_prev_d;
    int          m_run_sd, m_run_d;   // consecutive edges the pins held their value

    // A pin value held for exactly S edges is sampled on the following edge;
    // a strobe held for exactly T edges stalls on the following edge.
    always @(posedge clk_50MHz or posedge reset_button) begin
        logic       sample, timeout, completing;
        logic [3:0] seen_new;
        int         v, idx;
        if (reset_button) begin
            m_bcd = 0; m_shadow = 0; m_valid = 0; m_ep = 0; m_ed = 0; m_stale = 0;
            m_seen = 0; m_prev_seg = 0; m_prev_d = 0;
            // The zeroed input registers look like a value already steady for two edges.
            m_run_sd = 2; m_run_d = 2;
        end else begin
            sample     = (m_run_sd == S);
            timeout    = (m_run_d == T);
            completing = (m_seen == 4'hF);
            m_valid    = 1'b0;
            seen_new   = m_seen;
            if (completing) begin
                m_bcd    = m_shadow;
                m_valid  = 1'b1;
                m_stale  = 1'b0;
                seen_new = 4'h0;
            end
            if (sample) begin
                v = decode_ref(m_prev_seg);
                if (v < 0) m_ep = 1'b1;
                if ($countones(m_prev_d) != 1) m_ed = 1'b1;
                if ($countones(m_prev_d) == 1 && v >= 0) begin
                    idx = $clog2(m_prev_d);
                    m_shadow[idx*4 +: 4] = 4'(v);
                    seen_new[idx] = 1'b1;
                end
            end
            if (timeout && !completing && seen_new != 4'hF) begin
                m_stale  = 1'b1;
                seen_new = 4'h0;
            end
            m_seen = seen_new;
            if (seg == m_prev_seg && digit == m_prev_d) begin
                if (m_run_sd < 1_000_000) m_run_sd++;
            end else m_run_sd = 1;
            if (digit == m_prev_d) begin
                if (m_run_d < 1_000_000) m_run_d++;
            end else m_run_d = 1;
            m_prev_seg = seg;
            m_prev_d   = digit;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk_50MHz) begin
        check("outputs_vs_model", {12'h0, bcd, valid, err_pattern, err_digit, stale},
              {12'h0, m_bcd, m_valid, m_ep, m_ed, m_stale});
        if (valid) n_valid_dut++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
        digit = d;
        seg   = s;
        repeat (n) begin
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    // pats = {thousands, hundreds, tens, ones}
    task automatic scan(input logic [31:0] pats);
        hold(4'b0001, pats[7:0],   DWELL);
        hold(4'b0010, pats[15:8],  DWELL);
        hold(4'b0100, pats[23:16], DWELL);
        hold(4'b1000, pats[31:24], DWELL);
    endtask

    typedef struct {
        logic [31:0] pats;
        logic [15:0] exp_bcd;
        int          exp_valids;
        logic        exp_err_pattern;
    } scan_vec_t;

    scan_vec_t tbl [6];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v0;
        logic [3:0] bad_d [4] = '{4'b0011, 4'b0101, 4'b1100, 4'b1111};

        tbl[0] = '{32'h0149990D, 16'h8543, 1, 1'b0};
        tbl[1] = '{32'h1F259F03, 16'h7210, 1, 1'b0};
        tbl[2] = '{32'h091F4149, 16'h9765, 1, 1'b0};
        tbl[3] = '{32'h0149FF0D, 16'h9765, 0, 1'b1};  // bad tens: no frame
        tbl[4] = '{32'h1F990941, 16'h8596, 1, 1'b1};  // good tens completes old frame
        tbl[5] = '{32'h03030303, 16'h7400, 1, 1'b1};

        // Power-up reset with the ones strobe already on the bus.
        @(posedge clk_50MHz); #1;
        reset_button = 1'b1;
        repeat (3) begin @(posedge clk_50MHz); #1; end
        check("reset_bcd", bcd, 16'h0);
        check("reset_flags", {valid, err_pattern, err_digit, stale}, 4'b0000);
        reset_button = 1'b0;

        // Table-driven scans.
        for (int i = 0; i < 6; i++) begin
            v0 = n_valid_dut;
            scan(tbl[i].pats);
            check($sformatf("scan%0d_bcd", i), bcd, tbl[i].exp_bcd);
            check($sformatf("scan%0d_valids", i), n_valid_dut - v0, tbl[i].exp_valids);
            check($sformatf("scan%0d_err_pattern", i), err_pattern, tbl[i].exp_err_pattern);
            check($sformatf("scan%0d_err_digit", i), err_digit, 1'b0);
        end

        // Multi-hot strobe: flagged, and the partial frame (hundreds, thousands) survives.
        v0 = n_valid_dut;
        hold(4'b0011, 8'h9F, 3 * S);
        check("multihot_err_digit", err_digit, 1'b1);
        check("multihot_no_valid", n_valid_dut - v0, 0);
        hold(4'b0001, 8'h9F, DWELL);
        hold(4'b0010, 8'h25, DWELL);
        check("multihot_seen_kept_bcd", bcd, 16'h0021);
        check("multihot_seen_kept_valids", n_valid_dut - v0, 1);

        // Short glitch of a one inside a zero dwell never gets sampled.
        v0 = n_valid_dut;
        hold(4'b0001, 8'h03, S + 5);
        hold(4'b0001, 8'h9F, S / 2);
        hold(4'b0001, 8'h03, S + 5);
        hold(4'b0010, 8'h25, DWELL);
        hold(4'b0100, 8'h0D, DWELL);
        hold(4'b1000, 8'h99, DWELL);
        check("glitch_bcd", bcd, 16'h4320);
        check("glitch_valids", n_valid_dut - v0, 1);

        // Stall after two digits: stale rises and the partial frame is dropped.
        v0 = n_valid_dut;
        hold(4'b0001, 8'h9F, DWELL);
        hold(4'b0010, 8'h25, T + 20);
        check("stall_stale", stale, 1'b1);
        check("stall_bcd_kept", bcd, 16'h4320);
        hold(4'b0100, 8'h41, DWELL);
        hold(4'b1000, 8'h1F, DWELL);
        check("stall_partial_dropped", n_valid_dut - v0, 0);
        check("stall_still_stale", stale, 1'b1);
        hold(4'b0001, 8'h99, DWELL);
        hold(4'b0010, 8'h49, DWELL);
        check("resume_bcd", bcd, 16'h7654);
        check("resume_valids", n_valid_dut - v0, 1);
        check("resume_stale_clear", stale, 1'b0);

        // Reset after three digits: outputs clear at once, partial frame discarded.
        hold(4'b0001, 8'h03, DWELL);
        hold(4'b0010, 8'h9F, DWELL);
        hold(4'b0100, 8'h25, DWELL);
        reset_button = 1'b1;
        #1;
        check("midreset_bcd", bcd, 16'h0);
        check("midreset_flags", {valid, err_pattern, err_digit, stale}, 4'b0000);
        repeat (3) begin @(posedge clk_50MHz); #1; end
        reset_button = 1'b0;
        v0 = n_valid_dut;
        hold(4'b1000, 8'h0D, DWELL);
        check("midreset_no_valid", n_valid_dut - v0, 0);
        scan(32'h990D259F);
        check("midreset_next_bcd", bcd, 16'h3321);
        check("midreset_next_valids", n_valid_dut - v0, 1);
        check("midreset_errs_clear", {err_pattern, err_digit}, 2'b00);

        // Frame-completing sample on the same edge as the stall timeout.
        v0 = n_valid_dut;
        hold(4'b0001, 8'h41, DWELL);
        hold(4'b0010, 8'h1F, DWELL);
        hold(4'b0100, 8'h01, DWELL);
        check("pre_tie_bcd", bcd, 16'h4876);
        hold(4'b0001, 8'h09, DWELL);
        hold(4'b0010, 8'h03, DWELL);
        hold(4'b0100, 8'h9F, DWELL);
        hold(4'b1000, 8'hFF, T - S);
        hold(4'b1000, 8'h25, S + 20);
        check("tie_bcd", bcd, 16'h2109);
        check("tie_valids", n_valid_dut - v0, 2);
        check("tie_stale_low", stale, 1'b0);
        check("tie_err_pattern", err_pattern, 1'b1);

        // Randomized bus activity, checked against the model every cycle.
        for (int i = 0; i < 150; i++) begin
            logic [3:0] d;
            logic [7:0] s;
            int         n;
            d = ($urandom_range(0, 9) == 0) ? bad_d[$urandom_range(0, 3)]
                                            : 4'(4'b0001 << $urandom_range(0, 3));
            s = ($urandom_range(0, 6) == 0) ? 8'($urandom) : ref_pat[$urandom_range(0, 9)];
            n = ($urandom_range(0, 19) == 0) ? T + 5 : $urandom_range(S / 2, 3 * S);
            hold(d, s, n);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side monitor for the board's multiplexed 4-digit seven-segment bus. It samples the `seg`/`digit` lines that the display controller drives. Once each digit strobe has settled, it decodes the active-low segment pattern back to a BCD nibble and assembles a 16-bit BCD word. The block is used in loopback self-test: counter BCD → display driver → `seg7_capture` → compare. It also flags malformed strobes, unknown patterns and a stalled scan.

## Interface
- `SETTLE_CYCLES`, default 1000: cycles that `digit` and `seg` must hold unchanged before a sample is taken; must be less than the driver dwell of 50,000.
- `TIMEOUT_CYCLES`, default 200_000: cycles without a `digit` change before `stale` is raised; must be greater than `SETTLE_CYCLES`.
- `clk_50MHz` in 1: single clock; everything is on its rising edge.
- `reset_button` in 1: asynchronous, active-high reset.
- `seg` in 8: active-low segment pattern; bit 0 is the decimal point and is ignored.
- `digit` in 4: one-hot digit select; 0001 = ones, 0010 = tens, 0100 = hundreds, 1000 = thousands.
- `bcd` out 16: last complete frame; [3:0] ones … [15:12] thousands.
- `valid` out 1: one-cycle pulse when `bcd` is updated.
- `err_pattern` out 1: sticky; an undecodable pattern was sampled.
- `err_digit` out 1: sticky; a settled `digit` was zero or multi-hot.
- `stale` out 1: scan stalled; cleared by the next `valid`.

## Operation
- `seg` and `digit` are registered once on entry. All logic uses the registered copies `seg_r`/`digit_r`.
- Settle counter:
  - Clears whenever `seg_r` or `digit_r` differs from the previous cycle.
  - Otherwise counts up and saturates at `SETTLE_CYCLES-1`.
  - A sample fires exactly once per stable dwell, on the cycle the counter first reaches `SETTLE_CYCLES-1`.
- At a sample:
  - **`digit_r` not one-hot:** set `err_digit`; no shadow write.
  - **Decode `seg_r[7:1]`:** 0x03→0, 0x9F→1, 0x25→2, 0x0D→3, 0x99→4, 0x49→5, 0x41→6, 0x1F→7, 0x01→8, 0x09→9 (values are the full 8-bit patterns with bit 0 = 1).
  - **Pattern not in the table:** set `err_pattern`; no shadow write; that digit's `seen` bit stays clear.
  - **Valid pattern:** write the nibble into shadow[idx] and set `seen[idx]`.
- Frame completion: the cycle after `seen` becomes 4'b1111:
  - shadow → `bcd`;
  - `valid`=1 for one cycle;
  - `seen` cleared;
  - `stale` cleared.
- Resampling: a digit sampled again before the frame completes overwrites its shadow nibble. The newest value wins.
- Stall counter:
  - Clears on any `digit_r` change.
  - At `TIMEOUT_CYCLES-1` it sets `stale` and clears `seen`, so no partial frame survives a stall. It then saturates.
  - Shadow contents are kept.
- Reset mid-frame: all state is cleared immediately; the partial frame is discarded.

## Timing
- Reset values: `bcd`=16'h0000, `valid`=0, `err_pattern`=0, `err_digit`=0, `stale`=0, `seen`=0, shadow=0, both counters=0.
- Sample point: `SETTLE_CYCLES` + 1 cycles after a `seg`/`digit` change at the pins. The extra cycle is the input register.
- `valid` latency: 1 cycle after the fourth distinct digit's sample. `bcd` changes on that same edge and holds until the next frame.
- At the driver's 1 ms dwell, a full frame completes every 4 ms after the first complete scan.
- Simultaneous events:
  - A sample completing the frame and the timeout in the same cycle: the sample and frame completion win; `stale` stays 0.
  - Error flags are sticky and independent of `valid`; only reset clears them.
- Glitches shorter than `SETTLE_CYCLES` never cause a sample.

## Structure
- `seg7_pkg` holds the ten pattern constants ZERO…NINE (same encoding as the display driver) and the digit one-hot constants.
- Sub-module `seg7_pattern_decode`: combinational; 7-bit pattern in, 4-bit nibble and `ok` flag out.
- Top level holds:
  - input registers;
  - settle and stall counters;
  - `seen` and shadow registers;
  - frame/flag logic.
- Counter widths are `$clog2` of the respective parameter.

## Test plan
- Drive digits 0001/0010/0100/1000 with patterns 0x0D/0x99/0x49/0x01, dwell 50,000 each -> `valid` pulses once after the 4th sample, `bcd`=16'h8543, no errors.
- Same scan, but the tens pattern is 0xFF -> `err_pattern`=1; no `valid` until a later scan with a good tens pattern. Then `bcd` updates and `err_pattern` stays 1.
- `digit`=0011 held for 2000 cycles -> `err_digit`=1, `seen` unchanged.
- A 500-cycle glitch of `seg`=0x9F inside a dwell of 0x03 (SETTLE_CYCLES=1000) -> nibble stays 0; exactly one sample per dwell.
- Freeze `digit` after 2 digits for 200,000 cycles -> `stale`=1, partial frame dropped. Resume scanning -> the next full scan gives `valid` and `stale`=0.
- Assert `reset_button` after 3 digits sampled -> all outputs 0 immediately; the next complete scan is needed before `valid`.
